// File: rtl/dpram_128x8_fifo_ctrl.sv
// dpram_128x8_fifo_ctrl: push/pop FIFO controller driving both ports of dpram_128x8; DPRAM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags
module dpram_128x8_fifo_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int AFULL_LVL  = 120,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              push,
  input  logic [0:DATA_W-1] push_data,
  input  logic              pop,
  output logic [0:DATA_W-1] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [0:ADDR_W]   count,
  output logic              ram_wen,
  output logic [0:ADDR_W-1] ram_waddr,
  output logic [0:DATA_W-1] ram_data_in,
  output logic              ram_ren,
  output logic [0:ADDR_W-1] ram_raddr,
  input  logic [0:DATA_W-1] ram_data_out
);
  localparam logic [ADDR_W:0] AF_LVL = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL = AEMPTY_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] WRAP   = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W:0] wptr, rptr, cnt;
  logic            wr_acc, pop_acc;
  assign empty        = wptr == rptr;
  assign full         = (wptr ^ rptr) == WRAP;
  assign almost_full  = cnt >= AF_LVL;
  assign almost_empty = cnt <= AE_LVL;
  assign count        = cnt;
  assign pop_acc      = pop & ~empty;
  assign wr_acc       = push & (~full | pop_acc);
  assign ram_wen      = wr_acc;
  assign ram_waddr    = wptr[ADDR_W-1:0];
  assign ram_data_in  = push_data;
  assign ram_ren      = pop_acc;
  assign ram_raddr    = rptr[ADDR_W-1:0];
  assign pop_data     = ram_data_out;
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      pop_valid <= 1'b0;
    end else begin
      wptr      <= wptr + {{ADDR_W{1'b0}}, wr_acc};
      rptr      <= rptr + {{ADDR_W{1'b0}}, pop_acc};
      cnt       <= cnt + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, pop_acc};
      pop_valid <= pop_acc;
    end
  end
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (push & full & ~pop);
      underflow <= underflow | (pop & empty);
    end
  end
`endif
endmodule

// File: tb/tb_dpram_128x8_fifo_ctrl.sv
// tb_dpram_128x8_fifo_ctrl: directed bench for the FIFO controller with a behavioural dpram_128x8 model
module tb_dpram_128x8_fifo_ctrl;
  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       push = 1'b0, pop = 1'b0;
  logic [0:7] push_data = '0;
  logic [0:7] pop_data, ram_data_in, ram_data_out;
  logic       pop_valid, full, empty, almost_full, almost_empty;
  logic [0:7] count;
  logic       ram_wen, ram_ren;
  logic [0:6] ram_waddr, ram_raddr;
  logic [7:0] mem [128];
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  dpram_128x8_fifo_ctrl dut (
    .clk(clk), .R(R), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .count(count), .ram_wen(ram_wen), .ram_waddr(ram_waddr),
    .ram_data_in(ram_data_in), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram_data_out(ram_data_out)
  );
  always_ff @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_data_in;
    if (ram_ren) ram_data_out <= mem[ram_raddr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_pvalid", 32'(pop_valid), 0);
    #8 R = 1'b0;
    step();
    push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_data = 8'(i);
      #1;
      chk("p5_wen", 32'(ram_wen), 1);
      chk("p5_waddr", 32'(ram_waddr), 32'(i - 1));
      step();
    end
    push = 1'b0;
    chk("p5_count", 32'(count), 5);
    pop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("p5_pvalid", 32'(pop_valid), 1);
      chk("p5_data", 32'(pop_data), 32'(i));
    end
    pop = 1'b0;
    chk("p5_count_end", 32'(count), 0);
    chk("p5_empty_end", 32'(empty), 1);
    step();
    chk("p5_pvalid_end", 32'(pop_valid), 0);
    push = 1'b1;
    for (int i = 0; i < 128; i++) begin
      push_data = 8'(i);
      if (i == 119) chk("afull_119", 32'(almost_full), 0);
      if (i == 120) chk("afull_120", 32'(almost_full), 1);
      if (i == 8) chk("aempty_8", 32'(almost_empty), 1);
      if (i == 9) chk("aempty_9", 32'(almost_empty), 0);
      step();
    end
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), 128);
    push_data = 8'hFF;
    #1;
    chk("ovf_wen", 32'(ram_wen), 0);
    step();
    chk("ovf_count", 32'(count), 128);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(overflow), 1);
`endif
    push_data = 8'hAA;
    pop = 1'b1;
    #1;
    chk("fpp_wen", 32'(ram_wen), 1);
    chk("fpp_ren", 32'(ram_ren), 1);
    step();
    push = 1'b0;
    chk("fpp_pvalid", 32'(pop_valid), 1);
    chk("fpp_data", 32'(pop_data), 8'h00);
    chk("fpp_count", 32'(count), 128);
    for (int i = 0; i < 128; i++) begin
      step();
      if (i == 0) chk("drain_first", 32'(pop_data), 8'h01);
      if (i == 122) chk("drain_wrap", 32'(pop_data), 8'h7B);
    end
    pop = 1'b0;
    chk("drain_last", 32'(pop_data), 8'hAA);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'h3C;
    #1;
    chk("epp_ren", 32'(ram_ren), 0);
    chk("epp_wen", 32'(ram_wen), 1);
    step();
    push = 1'b0;
    chk("epp_pvalid", 32'(pop_valid), 0);
    chk("epp_count", 32'(count), 1);
    step();
    chk("epp_pop_valid", 32'(pop_valid), 1);
    chk("epp_pop_data", 32'(pop_data), 8'h3C);
    chk("epp_count0", 32'(count), 0);
    #1;
    chk("uf_ren", 32'(ram_ren), 0);
    step();
    pop = 1'b0;
    chk("uf_pvalid", 32'(pop_valid), 0);
    chk("uf_count", 32'(count), 0);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    chk("uf_flag", 32'(underflow), 1);
`endif
    push = 1'b1;
    for (int i = 0; i < 50; i++) begin
      push_data = 8'(8'h80 + i);
      step();
    end
    push = 1'b0;
    chk("ld50_count", 32'(count), 50);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("ld50_pvalid", 32'(pop_valid), 1);
    chk("ld50_data", 32'(pop_data), 8'h80);
    #2 R = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_pvalid", 32'(pop_valid), 0);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_uf", 32'(underflow), 0);
`endif
    #2 R = 1'b0;
    push = 1'b1;
    push_data = 8'h5A;
    #1;
    chk("post_waddr", 32'(ram_waddr), 0);
    step();
    push = 1'b0;
    chk("post_count", 32'(count), 1);
    pop = 1'b1;
    #1;
    chk("post_raddr", 32'(ram_raddr), 0);
    step();
    pop = 1'b0;
    chk("post_pvalid", 32'(pop_valid), 1);
    chk("post_data", 32'(pop_data), 8'h5A);
    chk("post_empty", 32'(empty), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
